// File: rtl/muldiv_iter.sv
// Iterative RISC-V M-extension multiply/divide unit: one shift-add or restoring step per cycle.
// Define MULDIV_FAST_SPECIAL_EN to finish divide-by-zero and signed overflow straight from LOAD.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             stall,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ITER  = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [2:0]       funct3_q;
    logic [WIDTH-1:0] op_a_q, op_b_q;
    logic [WIDTH-1:0] mag_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             neg_a_q, neg_b_q;
    logic [WIDTH-1:0] result_q;
    logic             busy_q, ready_q;

    logic             is_div, signed_a, signed_b;
    logic             neg_a_d, neg_b_d;
    logic [WIDTH-1:0] mag_a_d, mag_b_d;
    logic             div_zero, div_ovf;
    logic [WIDTH-1:0] special_d;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0] hi_d, lo_d;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] quo_s, rem_s;
    logic [WIDTH-1:0] fixup_d;

    // Operand decode and magnitude conversion work on the captured copies only.
    always_comb begin
        is_div   = funct3_q[2];
        signed_a = (funct3_q == 3'b000) || (funct3_q == 3'b001) || (funct3_q == 3'b010) ||
                   (funct3_q == 3'b100) || (funct3_q == 3'b110);
        signed_b = (funct3_q == 3'b000) || (funct3_q == 3'b001) ||
                   (funct3_q == 3'b100) || (funct3_q == 3'b110);
        neg_a_d  = signed_a && op_a_q[WIDTH-1];
        neg_b_d  = signed_b && op_b_q[WIDTH-1];
        mag_a_d  = neg_a_d ? (~op_a_q + 1'b1) : op_a_q;
        mag_b_d  = neg_b_d ? (~op_b_q + 1'b1) : op_b_q;

        div_zero = (op_b_q == '0);
        div_ovf  = signed_a && (op_a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b_q == '1);
        if (funct3_q[1])
            special_d = div_zero ? op_a_q : '0;
        else
            special_d = div_zero ? '1 : op_a_q;
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mag_q};
        if (is_div) begin
            if (!div_diff[WIDTH]) begin
                hi_d = div_diff[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = div_shift[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_d = mul_sum[WIDTH:1];
            lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // Sign restoration and final result selection.
    always_comb begin
        prod_s = (neg_a_q ^ neg_b_q) ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
        quo_s  = (neg_a_q ^ neg_b_q) ? (~lo_q + 1'b1) : lo_q;
        rem_s  = neg_a_q ? (~hi_q + 1'b1) : hi_q;
        if (is_div) begin
            if (div_zero || div_ovf)
                fixup_d = special_d;
            else
                fixup_d = funct3_q[1] ? rem_s : quo_s;
        end else begin
            fixup_d = (funct3_q[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
        end
    end

    // NOTE: every register below is updated with <= so all reads see pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            funct3_q <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            mag_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        funct3_q <= funct3;
                        op_a_q   <= opA;
                        op_b_q   <= opB;
                        busy_q   <= 1'b1;
                        state_q  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    neg_a_q <= neg_a_d;
                    neg_b_q <= neg_b_d;
                    hi_q    <= '0;
                    if (is_div) begin
                        mag_q <= mag_b_d;
                        lo_q  <= mag_a_d;
                    end else begin
                        mag_q <= mag_a_d;
                        lo_q  <= mag_b_d;
                    end
`ifdef MULDIV_FAST_SPECIAL_EN
                    if (is_div && (div_zero || div_ovf)) begin
                        result_q <= special_d;
                        ready_q  <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q   <= CW'(WIDTH);
                        state_q <= S_ITER;
                    end
`else
                    cnt_q   <= CW'(WIDTH);
                    state_q <= S_ITER;
`endif
                end
                S_ITER: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1))
                        state_q <= S_FIXUP;
                end
                S_FIXUP: begin
                    result_q <= fixup_d;
                    ready_q  <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    if (!stall) begin
                        busy_q  <= 1'b0;
                        ready_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign ready  = ready_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed self-checking bench for muldiv_iter at WIDTH=32.
// Special-case latency expectation follows MULDIV_FAST_SPECIAL_EN.
module tb_muldiv_iter;

    localparam int W = 32;

`ifdef MULDIV_FAST_SPECIAL_EN
    localparam int SPECIAL_LAT = 2;
`else
    localparam int SPECIAL_LAT = W + 3;
`endif
    localparam int NORMAL_LAT = W + 3;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         start;
    logic [2:0]   funct3;
    logic [W-1:0] opA, opB;
    logic         stall;
    logic         busy, ready;
    logic [W-1:0] result;

    int total = 0;
    int bad   = 0;

    muldiv_iter #(.WIDTH(W)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .start  (start),
        .funct3 (funct3),
        .opA    (opA),
        .opB    (opB),
        .stall  (stall),
        .busy   (busy),
        .ready  (ready),
        .result (result)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op, scramble inputs after capture, measure latency, optionally stall in DONE.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res,
                          input int exp_lat, input int hold);
        int n;
        logic busy_low;
        funct3 = f;
        opA    = a;
        opB    = b;
        start  = 1'b1;
        @(negedge Clk);
        start    = 1'b0;
        funct3   = 3'($urandom);
        opA      = $urandom;
        opB      = $urandom;
        n        = 1;
        busy_low = 1'b0;
        while (!ready && n < 200) begin
            if (busy !== 1'b1) busy_low = 1'b1;
            @(negedge Clk);
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(exp_lat));
        check({tag, "_busy"}, {63'd0, busy_low}, 64'd0);
        check({tag, "_res"}, 64'(result), 64'(exp_res));
        if (hold > 0) begin
            stall  = 1'b1;
            start  = 1'b1;
            funct3 = 3'b000;
            opA    = 32'd9;
            opB    = 32'd9;
            for (int k = 0; k < hold; k++) begin
                @(negedge Clk);
                check({tag, "_hold_rdy"}, {63'd0, ready}, 64'd1);
                check({tag, "_hold_res"}, 64'(result), 64'(exp_res));
            end
        end
        stall = 1'b0;
        start = 1'b0;
        @(negedge Clk);
        check({tag, "_idle"}, {62'd0, busy, ready}, 64'd0);
        check({tag, "_keep"}, 64'(result), 64'(exp_res));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset  = 1'b1;
        start  = 1'b0;
        stall  = 1'b0;
        funct3 = '0;
        opA    = '0;
        opB    = '0;
        repeat (2) @(negedge Clk);
        check("rst_state", {61'd0, busy, ready, 1'b0}, 64'd0);
        check("rst_result", 64'(result), 64'd0);
        Reset = 1'b0;
        @(negedge Clk);

        run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, NORMAL_LAT, 0);
        run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, NORMAL_LAT, 0);
        run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, NORMAL_LAT, 0);
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, NORMAL_LAT, 0);
        run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, NORMAL_LAT, 0);
        run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, NORMAL_LAT, 3);
        run_op("divu",   3'b101, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, NORMAL_LAT, 0);
        run_op("divu0",  3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, SPECIAL_LAT, 0);
        run_op("remu0",  3'b111, 32'd5,        32'd0,        32'd5,        SPECIAL_LAT, 0);
        run_op("div0s",  3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, SPECIAL_LAT, 0);
        run_op("rem0s",  3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, SPECIAL_LAT, 0);
        run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPECIAL_LAT, 0);
        run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        SPECIAL_LAT, 2);
        run_op("mulneg", 3'b000, 32'hFFFFFFFA, 32'hFFFFFFFB, 32'd30,       NORMAL_LAT, 0);

        // Abort a multiply part-way through ITER with a synchronous reset.
        funct3 = 3'b000;
        opA    = 32'h1234;
        opB    = 32'h10;
        start  = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        repeat (9) @(negedge Clk);
        check("mid_busy", {63'd0, busy}, 64'd1);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("mid_rst_state", {62'd0, busy, ready}, 64'd0);
        check("mid_rst_result", 64'(result), 64'd0);
        run_op("mul34", 3'b000, 32'd3, 32'd4, 32'd12, NORMAL_LAT, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
